conversor_comp2_serial: RTL and testbench
=========================================

CONVERSOR_COMP2_SERIAL -- requirements
Module: conversor_comp2_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 6, data word width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  input word and mode present.
REQ-005 SHALL have port in_ready  output  1  block can accept a word.
REQ-006 SHALL have port in_data  input  WIDTH  operand.
REQ-007 SHALL have port in_mode  input  2  operation: 00 NEG, 01 ABS, 10 SM2TC, 11 PASS.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer takes result.
REQ-010 SHALL have port out_data  output  WIDTH  result word.
REQ-011 SHALL have port out_ovf  output  1  result not representable in WIDTH bits.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-013 SHALL assert in_ready only in IDLE; accept when in_valid && in_ready, capture in_data and in_mode, go to SHIFT.
REQ-014 SHALL decide negation at accept: NEG always; ABS if in_data[WIDTH-1]=1; SM2TC if in_data[WIDTH-1]=1, operand magnitude = in_data with MSB cleared; PASS never.
REQ-015 SHALL process one bit per cycle LSB-first in SHIFT: when negating, copy bits up to and including the first 1, invert all later bits; else copy.
REQ-016 SHALL use a bit counter of $clog2(WIDTH) bits; leave SHIFT after bit WIDTH-1 is processed.
REQ-017 SHALL assert out_valid exactly WIDTH cycles after the accept edge; IDLE->SHIFT->DONE with no extra cycles.
REQ-018 SHALL hold out_data and out_ovf stable while out_valid && !out_ready; in_ready stays 0.
REQ-019 SHALL return to IDLE on the edge where out_valid && out_ready; next accept is possible on the following edge.
REQ-020 SHALL set out_ovf=1 only for NEG or ABS of the most-negative value (1 followed by WIDTH-1 zeros); out_ovf=0 otherwise.
REQ-021 SHALL map SM2TC of negative zero (1 followed by zeros) to all-zero with out_ovf=0.
REQ-022 SHALL keep out_data, out_ovf at their last values outside DONE; they are only meaningful with out_valid=1.
REQ-023 SHALL ignore in_valid, in_data and in_mode outside IDLE.

Reset
REQ-024 SHALL, on rst_n=0, immediately force state IDLE, counter 0, out_valid=0, out_data=0, out_ovf=0, in_ready=1 after release.
REQ-025 SHALL abort any in-progress SHIFT or DONE on reset; the aborted word is discarded with no output.

Configuration
REQ-026 SHALL honour macro COMP2_SAT_EN: when defined, an overflow result saturates to 0 followed by WIDTH-1 ones (max positive) with out_ovf=1.
REQ-027 SHALL, when COMP2_SAT_EN is undefined, return the wrapped result (1 followed by zeros) with out_ovf=1; no other behaviour differs.

Verification (WIDTH=6)
REQ-028 SHALL cover: NEG 000011 -> out_data 111101, out_ovf 0, out_valid exactly 6 cycles after accept.
REQ-029 SHALL cover: NEG 100000 -> 100000 ovf 1 without macro; 011111 ovf 1 with COMP2_SAT_EN.
REQ-030 SHALL cover: ABS 111010 -> 000110 ovf 0; ABS 010110 -> 010110 ovf 0; PASS 101010 -> 101010.
REQ-031 SHALL cover: SM2TC 100101 -> 111011; SM2TC 100000 -> 000000 ovf 0; SM2TC 000111 -> 000111.
REQ-032 SHALL cover: out_ready low 3 cycles in DONE -> out_data/out_ovf stable, in_ready 0, new in_valid ignored; accept resumes cycle after handshake.
REQ-033 SHALL cover: rst_n pulsed low mid-SHIFT (bit 3) -> out_valid 0, out_data 0 immediately; in_ready 1 after release; no stale result appears.

Source files
------------

// File: rtl/conversor_comp2_serial.sv
// Serial two's-complement converter: NEG / ABS / SM2TC / PASS, one bit per cycle, LSB first.
// Optional macro COMP2_SAT_EN saturates overflow results to the max positive value.
module conversor_comp2_serial #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    LAST     = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] SAT_VAL  = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t           state_r, state_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] opd_r, res_r, out_data_r, opd_s, res_next_s, final_s;
  logic             neg_r, seen_r, ovf_r, out_ovf_r, out_valid_r, in_ready_r;
  logic             neg_s, ovf_s, obit_s, accept_s, last_s;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_ovf   = out_ovf_r;

  assign accept_s = (state_r == IDLE) && in_valid;
  assign last_s   = (state_r == SHIFT) && (cnt_r == LAST);

  // Mode decode at accept: negate decision, operand magnitude and overflow flag
  always_comb begin
    neg_s = 1'b0;
    opd_s = in_data;
    case (in_mode)
      2'b00: neg_s = 1'b1;
      2'b01: neg_s = in_data[WIDTH-1];
      2'b10: begin
        neg_s            = in_data[WIDTH-1];
        opd_s[WIDTH-1]   = 1'b0;
      end
      default: neg_s = 1'b0;
    endcase
    ovf_s = ((in_mode == 2'b00) || (in_mode == 2'b01)) && (in_data == MOST_NEG);
  end

  // Serial negation: copy through the first 1, invert everything after it
  always_comb begin
    obit_s     = (neg_r && seen_r) ? ~opd_r[0] : opd_r[0];
    res_next_s = {obit_s, res_r[WIDTH-1:1]};
`ifdef COMP2_SAT_EN
    final_s = ovf_r ? SAT_VAL : res_next_s;
`else
    final_s = res_next_s;
`endif
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (in_valid) state_s = SHIFT; else state_s = IDLE;
      SHIFT:   if (last_s) state_s = DONE; else state_s = SHIFT;
      DONE:    if (out_ready) state_s = IDLE; else state_s = DONE;
      default: state_s = IDLE;
    endcase
  end

  // State register with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_s;
      out_valid_r <= (state_s == DONE);
      in_ready_r  <= (state_s == IDLE);
    end
  end

  // Operand capture, bit shifting and result publication
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= '0;
      opd_r      <= '0;
      res_r      <= '0;
      neg_r      <= 1'b0;
      seen_r     <= 1'b0;
      ovf_r      <= 1'b0;
      out_data_r <= '0;
      out_ovf_r  <= 1'b0;
    end else if (accept_s) begin
      cnt_r  <= '0;
      opd_r  <= opd_s;
      res_r  <= '0;
      neg_r  <= neg_s;
      seen_r <= 1'b0;
      ovf_r  <= ovf_s;
    end else if (state_r == SHIFT) begin
      cnt_r  <= cnt_r + CW'(1);
      opd_r  <= {1'b0, opd_r[WIDTH-1:1]};
      res_r  <= res_next_s;
      seen_r <= seen_r | opd_r[0];
      if (last_s) begin
        out_data_r <= final_s;
        out_ovf_r  <= ovf_r;
      end else begin
        out_data_r <= out_data_r;
        out_ovf_r  <= out_ovf_r;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: tb/tb_conversor_comp2_serial.sv
// Directed/scoreboard bench for conversor_comp2_serial at WIDTH=6 (tracks COMP2_SAT_EN).
module tb_conversor_comp2_serial;

  localparam int W = 6;
  localparam logic [W-1:0] MN  = 6'b100000;
  localparam logic [W-1:0] SAT = 6'b011111;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic [1:0]   in_mode = 2'b00;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_ovf;

  int checks = 0;
  int errors = 0;
  logic [W:0] sb_q[$];

  conversor_comp2_serial #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Arithmetic reference, independent of the serial bit algorithm
  function automatic logic [W:0] model(input logic [W-1:0] d, input logic [1:0] m);
    logic [W-1:0] r, mag;
    logic o;
    o = 1'b0;
    case (m)
      2'b00: begin r = W'(0) - d; o = (d == MN); end
      2'b01: begin r = d[W-1] ? W'(0) - d : d; o = (d == MN); end
      2'b10: begin mag = d & SAT; r = d[W-1] ? W'(0) - mag : d; end
      default: r = d;
    endcase
`ifdef COMP2_SAT_EN
    if (o) r = SAT;
`endif
    return {o, r};
  endfunction

  // Drive one word, verify latency, hold out_ready low for 'hold' cycles, then handshake
  task automatic send(input logic [W-1:0] d, input logic [1:0] m, input int hold,
                      input logic [W:0] exp);
    int lat;
    logic [W:0] e;
    logic [W-1:0] held;
    chk("in_ready_before_send", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = d; in_mode = m;
    sb_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b1; in_data = ~d; in_mode = ~m;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", 32'(lat), 32'(W));
    e = sb_q.pop_front();
    chk("out_data", 32'(out_data), 32'(e[W-1:0]));
    chk("out_ovf", 32'(out_ovf), 32'(e[W]));
    held = out_data;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; in_data = 6'b010101; in_mode = 2'b11;
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'(out_data), 32'(held));
      chk("hold_ovf", 32'(out_ovf), 32'(e[W]));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_hs_valid", 32'(out_valid), 32'd0);
    chk("post_hs_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [W-1:0] rd;
    logic [1:0]   rm;
    logic         seen_valid;
    #12;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);
    chk("reset_out_ovf", 32'(out_ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 32'(in_ready), 32'd1);

    send(6'b000011, 2'b00, 0, {1'b0, 6'b111101});
`ifdef COMP2_SAT_EN
    send(6'b100000, 2'b00, 0, {1'b1, 6'b011111});
    send(6'b100000, 2'b01, 0, {1'b1, 6'b011111});
`else
    send(6'b100000, 2'b00, 0, {1'b1, 6'b100000});
    send(6'b100000, 2'b01, 0, {1'b1, 6'b100000});
`endif
    send(6'b111010, 2'b01, 0, {1'b0, 6'b000110});
    send(6'b010110, 2'b01, 0, {1'b0, 6'b010110});
    send(6'b101010, 2'b11, 0, {1'b0, 6'b101010});
    send(6'b100101, 2'b10, 0, {1'b0, 6'b111011});
    send(6'b100000, 2'b10, 0, {1'b0, 6'b000000});
    send(6'b000111, 2'b10, 3, {1'b0, 6'b000111});
    send(6'b000001, 2'b00, 0, {1'b0, 6'b111111});
    for (int i = 0; i < 10; i++) begin
      rd = W'($urandom);
      rm = 2'($urandom_range(0, 3));
      send(rd, rm, int'($urandom_range(0, 2)), model(rd, rm));
    end
    send(6'b000110, 2'b00, 0, model(6'b000110, 2'b00));

    // Reset during SHIFT: the in-flight word must vanish
    in_valid = 1'b1; in_data = 6'b001011; in_mode = 2'b00;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_data", 32'(out_data), 32'd0);
    chk("rst_mid_ovf", 32'(out_ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_in_ready", 32'(in_ready), 32'd1);
    seen_valid = 1'b0;
    repeat (2 * W) begin
      @(negedge clk);
      seen_valid = seen_valid | out_valid;
    end
    chk("no_stale_result", 32'(seen_valid), 32'd0);
    send(6'b011001, 2'b00, 0, {1'b0, 6'b100111});
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
